// File: rtl/note_tone_generator_pkg.sv
// Shared definitions for the note tone generator: FSM encoding, codec sample width
// and the millisecond cycle-count derivation.
package note_tone_generator_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Width of one sample word on the audio codec write port.
    localparam int unsigned CODEC_SAMPLE_WIDTH = 32;

    // Clock cycles per millisecond for a given system clock frequency in Hz.
    function automatic int unsigned ms_cycles(input int unsigned clock_frequency);
        return clock_frequency / 1000;
    endfunction

endpackage

// File: rtl/note_tone_generator_ms_tick_prescaler.sv
// Millisecond prescaler: counts 0..DIVIDE-1 and pulses tick on the wrap cycle.
// restart forces the count back to 0 on the next edge.
module ms_tick_prescaler #(
    parameter int unsigned DIVIDE = 50000
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(DIVIDE - 1);

    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_count_d;

    assign tick = (r_count == LastCount);

    // Next count: clear on restart or wrap, otherwise advance.
    always_comb begin
        w_count_d = r_count + 1'b1;
        if (restart || tick) begin
            w_count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

endmodule

// File: rtl/note_tone_generator.sv
// Plays one timed note as a signed square-wave sample stream: PLAY for duration_ms ms,
// then GAP_MS ms of silence, then a one-cycle note_done pulse.
module note_tone_generator
    import note_tone_generator_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned PERIOD_WIDTH    = 21,
    parameter int unsigned DUR_WIDTH       = 16,
    parameter int unsigned SAMPLE_WIDTH    = CODEC_SAMPLE_WIDTH,
    parameter int unsigned AMPLITUDE       = 10000000,
    parameter int unsigned GAP_MS          = 10
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [PERIOD_WIDTH-1:0] frequencyCount,
    input  logic                    note_start,
    input  logic [DUR_WIDTH-1:0]    duration_ms,
    input  logic                    sample_ready,
    output logic [SAMPLE_WIDTH-1:0] audio_sample,
    output logic                    audio_valid,
    output logic                    busy,
    output logic                    note_done
);

    localparam int unsigned MS_CYCLES = ms_cycles(CLOCK_FREQUENCY);
    localparam logic [DUR_WIDTH-1:0] GapLoad = DUR_WIDTH'(GAP_MS);
    localparam logic [SAMPLE_WIDTH-1:0] PosLevel = SAMPLE_WIDTH'(AMPLITUDE);
    localparam logic [SAMPLE_WIDTH-1:0] NegLevel = SAMPLE_WIDTH'(0) - PosLevel;

    state_e                  r_state, w_state_d;
    logic [PERIOD_WIDTH-1:0] r_period, w_period_d;
    logic [DUR_WIDTH-1:0]    r_ms_left, w_ms_left_d;
    logic [PERIOD_WIDTH-2:0] r_phase, w_phase_d;
    logic                    r_polarity, w_polarity_d;
    logic [SAMPLE_WIDTH-1:0] r_sample, w_sample_d;
    logic                    r_valid, r_busy, r_note_done;

    logic [PERIOD_WIDTH-2:0] w_half;
    logic                    w_tone_on;
    logic                    w_tick;
    logic                    w_restart;
    logic                    w_seg_end;

    assign w_half    = r_period[PERIOD_WIDTH-1:1];
    // Periods below 2 cycles cannot form a square wave; play silence instead.
    assign w_tone_on = (r_period >= PERIOD_WIDTH'(2));
    // Current PLAY/GAP segment ends this cycle (zero-length segments last one cycle).
    assign w_seg_end = (r_ms_left == '0) || (w_tick && (r_ms_left == DUR_WIDTH'(1)));
    // Prescaler restarts on every state entry and is held at 0 while idle.
    assign w_restart = (w_state_d != r_state) || (r_state == StIdle);

    ms_tick_prescaler #(
        .DIVIDE (MS_CYCLES)
    ) u_ms_tick_prescaler (
        .clock   (clock),
        .resetn  (resetn),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // FSM next state, ms down-counter and tone phase/polarity.
    always_comb begin
        w_state_d    = r_state;
        w_period_d   = r_period;
        w_ms_left_d  = r_ms_left;
        w_phase_d    = r_phase;
        w_polarity_d = r_polarity;
        unique case (r_state)
            StIdle: begin
                if (note_start) begin
                    w_state_d    = StPlay;
                    w_period_d   = frequencyCount;
                    w_ms_left_d  = duration_ms;
                    w_phase_d    = '0;
                    w_polarity_d = 1'b0;
                end
            end
            StPlay: begin
                if (w_seg_end) begin
                    w_state_d   = StGap;
                    w_ms_left_d = GapLoad;
                end else if (w_tick) begin
                    w_ms_left_d = r_ms_left - 1'b1;
                end
                if (w_tone_on) begin
                    if (r_phase == w_half - 1'b1) begin
                        w_phase_d    = '0;
                        w_polarity_d = ~r_polarity;
                    end else begin
                        w_phase_d = r_phase + 1'b1;
                    end
                end
            end
            StGap: begin
                if (w_seg_end) begin
                    w_state_d   = StIdle;
                    w_ms_left_d = '0;
                end else if (w_tick) begin
                    w_ms_left_d = r_ms_left - 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Sample level for the current cycle; presented on the port one cycle later.
    always_comb begin
        w_sample_d = '0;
        if ((r_state == StPlay) && w_tone_on) begin
            w_sample_d = r_polarity ? NegLevel : PosLevel;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_period    <= '0;
            r_ms_left   <= '0;
            r_phase     <= '0;
            r_polarity  <= 1'b0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_note_done <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_period    <= w_period_d;
            r_ms_left   <= w_ms_left_d;
            r_phase     <= w_phase_d;
            r_polarity  <= w_polarity_d;
            r_sample    <= w_sample_d;
            r_valid     <= sample_ready;
            r_busy      <= (w_state_d != StIdle);
            r_note_done <= (r_state == StGap) && (w_state_d == StIdle);
        end
    end

    assign audio_sample = r_sample;
    assign audio_valid  = r_valid;
    assign busy         = r_busy;
    assign note_done    = r_note_done;

endmodule

// File: tb/tb_note_tone_generator.sv
// Directed bench for note_tone_generator with MS_CYCLES=10, GAP_MS=2, AMPLITUDE=1000.
module tb_note_tone_generator;

    localparam int MS      = 10;
    localparam int GAP_LEN = 20;
    localparam int AMP     = 1000;

    logic        clock = 1'b0;
    logic        resetn;
    logic [20:0] frequencyCount;
    logic        note_start;
    logic [15:0] duration_ms;
    logic        sample_ready;
    logic [31:0] audio_sample;
    logic        audio_valid;
    logic        busy;
    logic        note_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic start;
        int   freq;
        int   dur;
        logic ready;
        logic exp_busy;
        logic exp_done;
        logic exp_valid;
        int   exp_sample;
    } vec_t;

    vec_t vecs[5];

    note_tone_generator #(
        .CLOCK_FREQUENCY (10000),
        .PERIOD_WIDTH    (21),
        .DUR_WIDTH       (16),
        .SAMPLE_WIDTH    (32),
        .AMPLITUDE       (1000),
        .GAP_MS          (2)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .frequencyCount (frequencyCount),
        .note_start     (note_start),
        .duration_ms    (duration_ms),
        .sample_ready   (sample_ready),
        .audio_sample   (audio_sample),
        .audio_valid    (audio_valid),
        .busy           (busy),
        .note_done      (note_done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Plays one note from an IDLE (or note_done) cycle and checks every cycle up to note_done.
    // Expected sample at observation k is the level of cycle k-1.
    task automatic play_note(input int freq, input int dur, input bit disturb);
        int play_len;
        int last;
        int exp_s;
        play_len = (dur == 0) ? 1 : dur * MS;
        last     = play_len + GAP_LEN + 1;
        frequencyCount = 21'(freq);
        duration_ms    = 16'(dur);
        note_start     = 1'b1;
        sample_ready   = 1'b1;
        for (int k = 1; k <= last; k++) begin
            step();
            note_start = 1'b0;
            exp_s = 0;
            if (k >= 2 && (k - 1) <= play_len && freq >= 2) begin
                exp_s = (((k - 2) / (freq / 2)) % 2 == 0) ? AMP : -AMP;
            end
            chk("note busy", int'(busy), int'(k < last));
            chk("note done", int'(note_done), int'(k == last));
            chk("note sample", $signed(audio_sample), exp_s);
            if (disturb && k == 10) begin
                note_start     = 1'b1;
                frequencyCount = 21'd4;
            end
        end
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{start: 1'b1, freq: 8, dur: 0, ready: 1'b1,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_valid: 1'b1, exp_sample: 0};
        vecs[1] = '{start: 1'b0, freq: 8, dur: 0, ready: 1'b0,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_valid: 1'b0, exp_sample: AMP};
        vecs[2] = '{start: 1'b0, freq: 8, dur: 0, ready: 1'b1,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_valid: 1'b1, exp_sample: 0};
        vecs[3] = '{start: 1'b0, freq: 8, dur: 0, ready: 1'b1,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_valid: 1'b1, exp_sample: 0};
        vecs[4] = '{start: 1'b0, freq: 8, dur: 0, ready: 1'b0,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_valid: 1'b0, exp_sample: 0};

        // Reset state
        resetn         = 1'b0;
        frequencyCount = '0;
        note_start     = 1'b0;
        duration_ms    = '0;
        sample_ready   = 1'b1;
        #2;
        chk("reset sample", $signed(audio_sample), 0);
        chk("reset valid", int'(audio_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(note_done), 0);
        step();
        resetn = 1'b1;
        step();
        chk("idle busy", int'(busy), 0);
        chk("idle valid", int'(audio_valid), 1);

        // Period 8, 3 ms note
        play_note(8, 3, 1'b0);

        // Zero-duration note with sample_ready pattern 1,0,1,1
        sample_ready = 1'b0;
        step();
        chk("tbl pre valid", int'(audio_valid), 0);
        for (int i = 0; i < 5; i++) begin
            note_start     = vecs[i].start;
            frequencyCount = 21'(vecs[i].freq);
            duration_ms    = 16'(vecs[i].dur);
            sample_ready   = vecs[i].ready;
            step();
            chk($sformatf("tbl%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("tbl%0d done", i), int'(note_done), int'(vecs[i].exp_done));
            chk($sformatf("tbl%0d valid", i), int'(audio_valid), int'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d sample", i), $signed(audio_sample), vecs[i].exp_sample);
        end
        note_start   = 1'b0;
        sample_ready = 1'b1;
        for (int k = 6; k <= 23; k++) begin
            step();
            chk("d0 busy", int'(busy), int'(k <= 21));
            chk("d0 done", int'(note_done), int'(k == 22));
            chk("d0 sample", $signed(audio_sample), 0);
        end

        // Unmapped key: silent 2 ms note
        play_note(0, 2, 1'b0);

        // Mid-note start and key change ignored; start in note_done cycle accepted
        play_note(8, 3, 1'b1);
        play_note(8, 0, 1'b0);

        // Asynchronous reset mid-PLAY
        frequencyCount = 21'd8;
        duration_ms    = 16'd3;
        note_start     = 1'b1;
        step();
        note_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("pre-abort busy", int'(busy), 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("abort sample", $signed(audio_sample), 0);
        chk("abort valid", int'(audio_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(note_done), 0);
        step();
        resetn = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (note_done) done_seen++;
        end
        chk("abort no done", done_seen, 0);
        chk("abort idle busy", int'(busy), 0);

        // Normal operation after abort
        play_note(4, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
